// File: rtl/contador_bcd_varredura_pkg.sv
// Shared types and constants for the scanned four-decade BCD counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package contador_bcd_varredura_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_DIGIT    = 4'd9;
  localparam int   NDIG         = 4;
  localparam int   SCAN_DIV_DEF = 4;

endpackage

// File: rtl/contador_bcd_varredura_if.sv
// Bundle of counter controls, count result and display scan outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts a control word every cycle.
interface contador_bcd_varredura_if;
  import contador_bcd_varredura_pkg::*;

  logic                en;
  logic                up;
  logic                load;
  logic [NDIG*4-1:0]   din;
  logic [NDIG*4-1:0]   count;
  logic                cout;
  bcd_t                bcd;
  logic [NDIG-1:0]     an;

  modport master (output en, up, load, din, input count, cout, bcd, an);
  modport slave  (input en, up, load, din, output count, cout, bcd, an);

endinterface

// File: rtl/contador_bcd_varredura_decada.sv
// One up/down BCD decade with saturating parallel load and ripple carry/borrow.
// Latency: q updates on the edge that samples load or cin; cout is combinational.
// Backpressure: none; steps whenever cin is high and load is low.
module decada_bcd
  import contador_bcd_varredura_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t din,
  input  logic up,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  bcd_t din_sat;

  // Out-of-range load nibbles clamp to 9 so the decade never holds a non-BCD value.
  assign din_sat = (din > MAX_DIGIT) ? MAX_DIGIT : din;

  // Carry/borrow out fires when this decade is about to wrap on the current step.
  assign cout = cin & (up ? (q == MAX_DIGIT) : (q == 4'd0));

  // Decade register: reset, then load, then a decimal step in the selected direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= din_sat;
    end else if (cin) begin
      if (up) begin
        q <= (q == MAX_DIGIT) ? 4'd0 : q + 4'd1;
      end else begin
        q <= (q == 4'd0) ? MAX_DIGIT : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/contador_bcd_varredura.sv
// Four-decade up/down BCD counter with multiplexed 7-segment digit scan.
// Latency: count/cout one cycle after en/load; bcd/an combinational from registers.
// Backpressure: none; one control word consumed per cycle, load wins over en.
module contador_bcd_varredura #(
  parameter int SCAN_DIV = contador_bcd_varredura_pkg::SCAN_DIV_DEF,
  parameter int NDIG     = contador_bcd_varredura_pkg::NDIG
) (
  input  logic                      clk,
  input  logic                      rst,
  contador_bcd_varredura_if.slave   bus
);
  import contador_bcd_varredura_pkg::*;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] DIV_TERM = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [NDIG*4-1:0] count_w;
  logic              wrap;
  logic              cout_q;
  logic [DW-1:0]     div_q;
  logic [IW-1:0]     idx_q;
  bcd_t              bcd_w;
  logic [NDIG-1:0]   an_w;

  // Ripple chain of decades: decade i steps only when every lower decade wraps.
  for (genvar i = 0; i < NDIG; i++) begin : g_dec
    logic ci;
    logic co;
    bcd_t q;
    if (i == 0) begin : g_first
      assign ci = bus.en;
    end else begin : g_next
      assign ci = g_dec[i-1].co;
    end
    decada_bcd u_dec (
      .clk  (clk),
      .rst  (rst),
      .load (bus.load),
      .din  (bus.din[4*i +: 4]),
      .up   (bus.up),
      .cin  (ci),
      .q    (q),
      .cout (co)
    );
    assign count_w[4*i +: 4] = q;
  end

  assign wrap = g_dec[NDIG-1].co;

  // Wrap pulse: registered so it lines up with the wrapped count; a load suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= wrap & ~bus.load;
    end
  end

  // Scan timing: divider free-runs regardless of en/load and advances the digit index on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_TERM) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Output mux: one-hot select plus the selected digit, straight from registered state.
  always_comb begin
    an_w        = '0;
    an_w[idx_q] = 1'b1;
    bcd_w       = count_w[4*idx_q +: 4];
  end

  assign bus.count = count_w;
  assign bus.cout  = cout_q;
  assign bus.bcd   = bcd_w;
  assign bus.an    = an_w;

endmodule
